// File: rtl/routing_table_csr.sv
// routing_table_csr
//   Egress routing table with a per-entry CSR responder and a sequential
//   first-match (longest-prefix, since the table is kept sorted) lookup engine.
//
//   Ports
//     clk, rst        : single clock, synchronous active-high reset
//     csr_req/csr_rsp : one CSR request/response channel per table entry
//                       (offsets 0 PREFIX, 4 MASK, 8 PEER, 12 DST)
//     lkp_valid/ready : lookup request handshake, lkp_ip is the address
//     res_valid/ready : result handshake; res_hit, res_index, res_dst_port,
//                       res_peer_id describe the first matching entry
package csr_pkg;
  typedef struct packed {
    logic        req;
    logic        req_is_wr;
    logic [3:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] wr_biten;
  } csr__dpe__routing_table__external__out_t;

  typedef struct packed {
    logic        wr_ack;
    logic        rd_ack;
    logic [31:0] rd_data;
  } csr__dpe__routing_table__external__in_t;
endpackage

module routing_table_csr #(
  parameter int ENTRY_COUNT = 64,
  parameter int IDX_W       = $clog2(ENTRY_COUNT)
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  csr_pkg::csr__dpe__routing_table__external__out_t csr_req [ENTRY_COUNT],
  output csr_pkg::csr__dpe__routing_table__external__in_t  csr_rsp [ENTRY_COUNT],
  input  logic                                             lkp_valid,
  input  logic [31:0]                                      lkp_ip,
  output logic                                             lkp_ready,
  output logic                                             res_valid,
  input  logic                                             res_ready,
  output logic                                             res_hit,
  output logic [IDX_W-1:0]                                 res_index,
  output logic [2:0]                                       res_dst_port,
  output logic [7:0]                                       res_peer_id
);

  typedef enum logic [1:0] {CSR_IDLE, CSR_ACK, CSR_HOLD} csr_state_e;
  typedef enum logic [1:0] {LKP_IDLE, LKP_SCAN, LKP_DONE} lkp_state_e;

  localparam logic [3:0] OFF_PREFIX = 4'd0;
  localparam logic [3:0] OFF_MASK   = 4'd4;
  localparam logic [3:0] OFF_PEER   = 4'd8;
  localparam logic [3:0] OFF_DST    = 4'd12;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_COUNT - 1);

  function automatic logic [31:0] apply_biten(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [31:0] be);
    return (cur & ~be) | (data & be);
  endfunction

  csr_state_e             csr_state_q [ENTRY_COUNT];
  csr_state_e             csr_state_d [ENTRY_COUNT];
  logic [31:0]            prefix_q    [ENTRY_COUNT];
  logic [31:0]            prefix_d    [ENTRY_COUNT];
  logic [31:0]            mask_q      [ENTRY_COUNT];
  logic [31:0]            mask_d      [ENTRY_COUNT];
  logic [7:0]             peer_q      [ENTRY_COUNT];
  logic [7:0]             peer_d      [ENTRY_COUNT];
  logic [2:0]             dst_q       [ENTRY_COUNT];
  logic [2:0]             dst_d       [ENTRY_COUNT];
  logic [31:0]            rd_data_q   [ENTRY_COUNT];
  logic [31:0]            rd_data_d   [ENTRY_COUNT];
  logic [ENTRY_COUNT-1:0] valid_q, valid_d;
  logic [ENTRY_COUNT-1:0] wr_ack_q, wr_ack_d;
  logic [ENTRY_COUNT-1:0] rd_ack_q, rd_ack_d;

  lkp_state_e       lkp_state_q, lkp_state_d;
  logic [31:0]      ip_q, ip_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             res_hit_q, res_hit_d;
  logic [IDX_W-1:0] res_index_q, res_index_d;
  logic [2:0]       res_dst_q, res_dst_d;
  logic [7:0]       res_peer_q, res_peer_d;
  logic             match;

  // CSR responders: the access happens in the IDLE cycle that samples req,
  // so the ack flops are loaded here and are high exactly during ACK.
  always_comb begin
    valid_d  = valid_q;
    wr_ack_d = '0;
    rd_ack_d = '0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      csr_state_d[i] = csr_state_q[i];
      prefix_d[i]    = prefix_q[i];
      mask_d[i]      = mask_q[i];
      peer_d[i]      = peer_q[i];
      dst_d[i]       = dst_q[i];
      rd_data_d[i]   = '0;
      unique case (csr_state_q[i])
        CSR_IDLE: begin
          if (csr_req[i].req) begin
            csr_state_d[i] = CSR_ACK;
            if (csr_req[i].req_is_wr) begin
              wr_ack_d[i] = 1'b1;
              // PREFIX is written last when (re)building an entry, so only it
              // re-enables the entry; any other field write takes it offline.
              case (csr_req[i].addr)
                OFF_PREFIX: begin
                  prefix_d[i] = apply_biten(prefix_q[i], csr_req[i].wr_data, csr_req[i].wr_biten);
                  valid_d[i]  = 1'b1;
                end
                OFF_MASK: begin
                  mask_d[i]  = apply_biten(mask_q[i], csr_req[i].wr_data, csr_req[i].wr_biten);
                  valid_d[i] = 1'b0;
                end
                OFF_PEER: begin
                  peer_d[i]  = 8'(apply_biten({24'd0, peer_q[i]}, csr_req[i].wr_data, csr_req[i].wr_biten));
                  valid_d[i] = 1'b0;
                end
                OFF_DST: begin
                  dst_d[i]   = 3'(apply_biten({29'd0, dst_q[i]}, csr_req[i].wr_data, csr_req[i].wr_biten));
                  valid_d[i] = 1'b0;
                end
                default: ;
              endcase
            end else begin
              rd_ack_d[i] = 1'b1;
              case (csr_req[i].addr)
                OFF_PREFIX: rd_data_d[i] = prefix_q[i];
                OFF_MASK:   rd_data_d[i] = mask_q[i];
                OFF_PEER:   rd_data_d[i] = {24'd0, peer_q[i]};
                OFF_DST:    rd_data_d[i] = {29'd0, dst_q[i]};
                default:    rd_data_d[i] = '0;
              endcase
            end
          end
        end
        CSR_ACK: begin
          csr_state_d[i] = csr_req[i].req ? CSR_HOLD : CSR_IDLE;
        end
        CSR_HOLD: begin
          if (!csr_req[i].req) csr_state_d[i] = CSR_IDLE;
        end
        default: csr_state_d[i] = CSR_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      csr_rsp[i].wr_ack  = wr_ack_q[i];
      csr_rsp[i].rd_ack  = rd_ack_q[i];
      csr_rsp[i].rd_data = rd_data_q[i];
    end
  end

  // Lookup engine: compares against registered table state, so a CSR write
  // landing on the examined entry in the same cycle is not seen.
  assign match = valid_q[idx_q] &&
                 ((ip_q & mask_q[idx_q]) == (prefix_q[idx_q] & mask_q[idx_q]));

  always_comb begin
    lkp_state_d = lkp_state_q;
    ip_d        = ip_q;
    idx_d       = idx_q;
    res_hit_d   = res_hit_q;
    res_index_d = res_index_q;
    res_dst_d   = res_dst_q;
    res_peer_d  = res_peer_q;
    unique case (lkp_state_q)
      LKP_IDLE: begin
        if (lkp_valid) begin
          ip_d        = lkp_ip;
          idx_d       = '0;
          lkp_state_d = LKP_SCAN;
        end
      end
      LKP_SCAN: begin
        if (match) begin
          res_hit_d   = 1'b1;
          res_index_d = idx_q;
          res_dst_d   = dst_q[idx_q];
          res_peer_d  = peer_q[idx_q];
          lkp_state_d = LKP_DONE;
        end else if (idx_q == LAST_IDX) begin
          res_hit_d   = 1'b0;
          res_index_d = '0;
          res_dst_d   = '0;
          res_peer_d  = '0;
          lkp_state_d = LKP_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      LKP_DONE: begin
        if (res_ready) lkp_state_d = LKP_IDLE;
      end
      default: lkp_state_d = LKP_IDLE;
    endcase
  end

  assign lkp_ready    = (lkp_state_q == LKP_IDLE);
  assign res_valid    = (lkp_state_q == LKP_DONE);
  assign res_hit      = res_hit_q;
  assign res_index    = res_index_q;
  assign res_dst_port = res_dst_q;
  assign res_peer_id  = res_peer_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        csr_state_q[i] <= CSR_IDLE;
        prefix_q[i]    <= '0;
        mask_q[i]      <= '0;
        peer_q[i]      <= '0;
        dst_q[i]       <= '0;
        rd_data_q[i]   <= '0;
      end
      valid_q     <= '0;
      wr_ack_q    <= '0;
      rd_ack_q    <= '0;
      lkp_state_q <= LKP_IDLE;
      ip_q        <= '0;
      idx_q       <= '0;
      res_hit_q   <= 1'b0;
      res_index_q <= '0;
      res_dst_q   <= '0;
      res_peer_q  <= '0;
    end else begin
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        csr_state_q[i] <= csr_state_d[i];
        prefix_q[i]    <= prefix_d[i];
        mask_q[i]      <= mask_d[i];
        peer_q[i]      <= peer_d[i];
        dst_q[i]       <= dst_d[i];
        rd_data_q[i]   <= rd_data_d[i];
      end
      valid_q     <= valid_d;
      wr_ack_q    <= wr_ack_d;
      rd_ack_q    <= rd_ack_d;
      lkp_state_q <= lkp_state_d;
      ip_q        <= ip_d;
      idx_q       <= idx_d;
      res_hit_q   <= res_hit_d;
      res_index_q <= res_index_d;
      res_dst_q   <= res_dst_d;
      res_peer_q  <= res_peer_d;
    end
  end

endmodule
